// File: rtl/ahb_sram_ctrl_64.sv
// ahb_sram_ctrl_64: AHB-Lite slave in front of a 1-cycle synchronous 1024x64 SRAM.
// Reads and writes complete with zero wait states on a single-port SRAM. A write
// data phase that collides with a read address phase is parked in a one-entry
// posted-write buffer, which is forwarded into read data and drained on a free cycle.
// Optional feature macro: AHB_SRAM_ERR_EN (error response for HSIZE>3 / misaligned).
module ahb_sram_ctrl_64 #(
  parameter int unsigned AW     = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [AW-1:0]     HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [63:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [63:0]       HRDATA,
  input  logic [63:0]       SRAMRDATA,
  output logic [7:0]        SRAMWEN,
  output logic [63:0]       SRAMWDATA,
  output logic              SRAMCS0,
  output logic [ADDR_W-1:0] SRAMADDR
);

  localparam int unsigned NB = 8;

`ifdef AHB_SRAM_ERR_EN
  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_e;

  state_e state_q, state_d;
`endif

  // Address-phase decode
  logic              accept;
  logic              addr_err;
  logic [1:0]        size_eff;
  logic [2:0]        off;
  logic [NB-1:0]     addr_mask;
  logic [ADDR_W-1:0] addr_word;
  logic              rd_acc;

  // Data-phase registers
  logic              dp_valid_q, dp_valid_d;
  logic              dp_write_q, dp_write_d;
  logic [ADDR_W-1:0] dp_addr_q,  dp_addr_d;
  logic [NB-1:0]     dp_mask_q,  dp_mask_d;

  // Posted-write buffer
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_addr_q,  buf_addr_d;
  logic [NB-1:0]     buf_mask_q,  buf_mask_d;
  logic [63:0]       buf_data_q,  buf_data_d;

  logic              wr_dp;
  logic              rd_dp;
  logic              drain;
  logic              fwd;

  // HTRANS[0] (SEQ vs NONSEQ) and address bits above the SRAM window do not matter
  logic              unused_bits;
  assign unused_bits = ^{HTRANS[0], HADDR[AW-1:ADDR_W+3]};

  // Decode accepted transfer: word address, byte mask and (optionally) error
  always_comb begin
    accept    = HSEL & HTRANS[1] & HREADY;
    addr_word = HADDR[ADDR_W+2:3];
    off       = HADDR[2:0];
    size_eff  = HSIZE[2] ? 2'd3 : HSIZE[1:0];
    case (size_eff)
      2'd0:    addr_mask = NB'(8'h01 << off);
      2'd1:    addr_mask = NB'(8'h03 << {off[2:1], 1'b0});
      2'd2:    addr_mask = NB'(8'h0F << {off[2], 2'b00});
      default: addr_mask = 8'hFF;
    endcase
`ifdef AHB_SRAM_ERR_EN
    case (size_eff)
      2'd0:    addr_err = 1'b0;
      2'd1:    addr_err = off[0];
      2'd2:    addr_err = |off[1:0];
      default: addr_err = |off;
    endcase
    if (HSIZE[2]) begin
      addr_err = 1'b1;
    end
`else
    addr_err = 1'b0;
`endif
    rd_acc = accept & ~HWRITE & ~addr_err;
    wr_dp  = dp_valid_q & dp_write_q;
    rd_dp  = dp_valid_q & ~dp_write_q;
    drain  = buf_valid_q & ~rd_acc & ~wr_dp;
    fwd    = buf_valid_q & (buf_addr_q == dp_addr_q);
  end

  // Next state of data-phase registers and posted-write buffer
  always_comb begin
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    dp_addr_d   = dp_addr_q;
    dp_mask_d   = dp_mask_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_mask_d  = buf_mask_q;
    buf_data_d  = buf_data_q;
    if (HREADY) begin
      dp_valid_d = accept & ~addr_err;
      dp_write_d = HWRITE;
      dp_addr_d  = addr_word;
      dp_mask_d  = addr_mask;
    end
    if (wr_dp && rd_acc) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = dp_addr_q;
      buf_mask_d  = dp_mask_q;
      buf_data_d  = HWDATA;
    end else if (drain) begin
      buf_valid_d = 1'b0;
    end
  end

  // SRAM port arbitration: read strobe, then direct write, then buffer drain
  always_comb begin
    SRAMCS0   = 1'b0;
    SRAMWEN   = '0;
    SRAMADDR  = '0;
    SRAMWDATA = '0;
    if (!HRESET) begin
      if (rd_acc) begin
        SRAMCS0  = 1'b1;
        SRAMADDR = addr_word;
      end else if (wr_dp) begin
        SRAMCS0   = 1'b1;
        SRAMWEN   = dp_mask_q;
        SRAMADDR  = dp_addr_q;
        SRAMWDATA = HWDATA;
      end else if (buf_valid_q) begin
        SRAMCS0   = 1'b1;
        SRAMWEN   = buf_mask_q;
        SRAMADDR  = buf_addr_q;
        SRAMWDATA = buf_data_q;
      end
    end
  end

  // Read data: SRAM output with buffered bytes forwarded over it
  always_comb begin
    HRDATA = '0;
    if (!HRESET && rd_dp) begin
      for (int b = 0; b < NB; b++) begin
        HRDATA[b*8 +: 8] = (fwd && buf_mask_q[b]) ? buf_data_q[b*8 +: 8] : SRAMRDATA[b*8 +: 8];
      end
    end
  end

`ifdef AHB_SRAM_ERR_EN
  // Error response sequencer: two-cycle ERROR after a bad transfer
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OK:   if (accept && addr_err) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = (accept && addr_err) ? ST_ERR1 : ST_OK;
      default: state_d = ST_OK;
    endcase
  end

  // Response outputs decoded from the error state
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    if (!HRESET) begin
      HREADYOUT = (state_q != ST_ERR1);
      HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    end
  end

  // Error state register
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_OK;
    end else begin
      state_q <= state_d;
    end
  end
`else
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
`endif

  // Data-phase and buffer registers; reset drops any pending buffered write
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_addr_q   <= '0;
      dp_mask_q   <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_mask_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_addr_q   <= dp_addr_d;
      dp_mask_q   <= dp_mask_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_mask_q  <= buf_mask_d;
      buf_data_q  <= buf_data_d;
    end
  end

endmodule

// File: tb/tb_ahb_sram_ctrl_64.sv
// Directed bench for ahb_sram_ctrl_64 with a behavioural 1-cycle SRAM model.
module tb_ahb_sram_ctrl_64;

  localparam int unsigned AW     = 32;
  localparam int unsigned ADDR_W = 10;
  localparam logic [1:0]  IDLE   = 2'b00;
  localparam logic [1:0]  BUSY   = 2'b01;
  localparam logic [1:0]  NSEQ   = 2'b10;

  logic              hclk = 1'b0;
  logic              hreset;
  logic              hsel;
  logic [AW-1:0]     haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [63:0]       hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [63:0]       hrdata;
  logic [63:0]       sram_rdata;
  logic [7:0]        sramwen;
  logic [63:0]       sramwdata;
  logic              sramcs0;
  logic [ADDR_W-1:0] sramaddr;

  logic [63:0]       mem [0:1023];

  int n_cmp = 0;
  int n_err = 0;

  assign hready = hreadyout;

  always #5 hclk = ~hclk;

  ahb_sram_ctrl_64 #(.AW(AW), .ADDR_W(ADDR_W)) dut (
    .HCLK      (hclk),
    .HRESET    (hreset),
    .HSEL      (hsel),
    .HADDR     (haddr),
    .HTRANS    (htrans),
    .HWRITE    (hwrite),
    .HSIZE     (hsize),
    .HWDATA    (hwdata),
    .HREADY    (hready),
    .HREADYOUT (hreadyout),
    .HRESP     (hresp),
    .HRDATA    (hrdata),
    .SRAMRDATA (sram_rdata),
    .SRAMWEN   (sramwen),
    .SRAMWDATA (sramwdata),
    .SRAMCS0   (sramcs0),
    .SRAMADDR  (sramaddr)
  );

  // SRAM macro model: byte-enabled write, registered read
  always @(posedge hclk) begin
    if (sramcs0) begin
      if (sramwen != 8'h00) begin
        for (int b = 0; b < 8; b++) begin
          if (sramwen[b]) mem[sramaddr][b*8 +: 8] <= sramwdata[b*8 +: 8];
        end
      end else begin
        sram_rdata <= mem[sramaddr];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic ap(input logic sel, input logic [1:0] tr, input logic wr,
                    input logic [2:0] sz, input logic [31:0] a);
    hsel   = sel;
    htrans = tr;
    hwrite = wr;
    hsize  = sz;
    haddr  = a;
  endtask

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  // A write data phase must never see a pending buffered write
  always @(negedge hclk) begin
    if (hreset === 1'b0 && dut.dp_valid_q && dut.dp_write_q)
      chk("buf_free_on_wr", 64'(dut.buf_valid_q), 64'd0);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 64'd0;
    sram_rdata = 64'd0;
    hreset = 1'b1;
    hwdata = 64'd0;
    ap(1'b1, NSEQ, 1'b0, 3'd3, 32'h08);
    tick();

    // Reset: outputs quiet even with a read presented
    @(negedge hclk);
    chk("rst_hreadyout", 64'(hreadyout), 64'd1);
    chk("rst_hresp", 64'(hresp), 64'd0);
    chk("rst_hrdata", hrdata, 64'd0);
    chk("rst_cs", 64'(sramcs0), 64'd0);
    chk("rst_wen", 64'(sramwen), 64'd0);
    chk("rst_addr", 64'(sramaddr), 64'd0);
    chk("rst_wdata", sramwdata, 64'd0);
    tick();
    hreset = 1'b0;
    ap(1'b0, IDLE, 1'b0, 3'd0, 32'h0);
    tick();

    // DW write @0x08, idle, read back
    ap(1'b1, NSEQ, 1'b1, 3'd3, 32'h08);
    @(negedge hclk); chk("t1_ap_cs", 64'(sramcs0), 64'd0); tick();
    ap(1'b0, IDLE, 1'b0, 3'd0, 32'h0); hwdata = 64'h1122334455667788;
    @(negedge hclk);
    chk("t1_wr_cs", 64'(sramcs0), 64'd1);
    chk("t1_wr_wen", 64'(sramwen), 64'hFF);
    chk("t1_wr_addr", 64'(sramaddr), 64'd1);
    chk("t1_wr_wdata", sramwdata, 64'h1122334455667788);
    tick();
    ap(1'b1, NSEQ, 1'b0, 3'd3, 32'h08);
    @(negedge hclk);
    chk("t1_rd_cs", 64'(sramcs0), 64'd1);
    chk("t1_rd_wen", 64'(sramwen), 64'd0);
    chk("t1_rd_addr", 64'(sramaddr), 64'd1);
    tick();
    ap(1'b0, IDLE, 1'b0, 3'd0, 32'h0);
    @(negedge hclk);
    chk("t1_hrdata", hrdata, 64'h1122334455667788);
    chk("t1_hreadyout", 64'(hreadyout), 64'd1);
    tick();

    // Byte write @0x0D then DW read @0x08
    ap(1'b1, NSEQ, 1'b1, 3'd0, 32'h0D); tick();
    ap(1'b0, IDLE, 1'b0, 3'd0, 32'h0); hwdata = 64'hABABABABABABABAB;
    @(negedge hclk); chk("t2_wen", 64'(sramwen), 64'h20); tick();
    ap(1'b1, NSEQ, 1'b0, 3'd3, 32'h08); tick();
    ap(1'b0, IDLE, 1'b0, 3'd0, 32'h0);
    @(negedge hclk); chk("t2_hrdata", hrdata, 64'h1122AB4455667788); tick();

    // W write @0x10 immediately followed by W read @0x10 (RAW via forwarding)
    ap(1'b1, NSEQ, 1'b1, 3'd2, 32'h10); tick();
    ap(1'b1, NSEQ, 1'b0, 3'd2, 32'h10); hwdata = 64'hDEADBEEFDEADBEEF;
    @(negedge hclk);
    chk("t3_coll_cs", 64'(sramcs0), 64'd1);
    chk("t3_coll_wen", 64'(sramwen), 64'd0);
    chk("t3_coll_addr", 64'(sramaddr), 64'd2);
    tick();
    ap(1'b0, IDLE, 1'b0, 3'd0, 32'h0); hwdata = 64'd0;
    @(negedge hclk);
    chk("t3_fwd", hrdata, 64'h00000000DEADBEEF);
    chk("t3_drain_cs", 64'(sramcs0), 64'd1);
    chk("t3_drain_wen", 64'(sramwen), 64'h0F);
    chk("t3_drain_addr", 64'(sramaddr), 64'd2);
    chk("t3_drain_wdata", sramwdata, 64'hDEADBEEFDEADBEEF);
    tick();
    ap(1'b1, NSEQ, 1'b0, 3'd3, 32'h10); tick();
    ap(1'b0, IDLE, 1'b0, 3'd0, 32'h0);
    @(negedge hclk); chk("t3_readback", hrdata, 64'h00000000DEADBEEF); tick();

    // W write @0x14, then reads @0x18, @0x20, @0x10 back-to-back
    ap(1'b1, NSEQ, 1'b1, 3'd2, 32'h14); tick();
    ap(1'b1, NSEQ, 1'b0, 3'd3, 32'h18); hwdata = 64'h13579BDF2468ACE0;
    @(negedge hclk);
    chk("t4_r1_wen", 64'(sramwen), 64'd0);
    chk("t4_r1_addr", 64'(sramaddr), 64'd3);
    tick();
    ap(1'b1, NSEQ, 1'b0, 3'd3, 32'h20); hwdata = 64'd0;
    @(negedge hclk);
    chk("t4_r2_buf", 64'(dut.buf_valid_q), 64'd1);
    chk("t4_r2_addr", 64'(sramaddr), 64'd4);
    chk("t4_r2_wen", 64'(sramwen), 64'd0);
    chk("t4_r1_data", hrdata, 64'd0);
    tick();
    ap(1'b1, NSEQ, 1'b0, 3'd3, 32'h10);
    @(negedge hclk);
    chk("t4_r3_buf", 64'(dut.buf_valid_q), 64'd1);
    chk("t4_r3_addr", 64'(sramaddr), 64'd2);
    tick();
    ap(1'b0, IDLE, 1'b0, 3'd0, 32'h0);
    @(negedge hclk);
    chk("t4_fwd", hrdata, 64'h13579BDFDEADBEEF);
    chk("t4_drain_cs", 64'(sramcs0), 64'd1);
    chk("t4_drain_addr", 64'(sramaddr), 64'd2);
    chk("t4_drain_wen", 64'(sramwen), 64'hF0);
    tick();
    @(negedge hclk);
    chk("t4_buf_empty", 64'(dut.buf_valid_q), 64'd0);
    chk("t4_idle_cs", 64'(sramcs0), 64'd0);
    tick();

    // Reset with a buffered write pending: write is discarded
    ap(1'b1, NSEQ, 1'b1, 3'd3, 32'h18); tick();
    ap(1'b0, IDLE, 1'b0, 3'd0, 32'h0); hwdata = 64'h0123456789ABCDEF; tick();
    ap(1'b1, NSEQ, 1'b1, 3'd3, 32'h18); tick();
    ap(1'b1, NSEQ, 1'b0, 3'd3, 32'h18); hwdata = 64'hFFFFFFFFFFFFFFFF; tick();
    ap(1'b0, IDLE, 1'b0, 3'd0, 32'h0); hreset = 1'b1;
    @(negedge hclk);
    chk("t5_rst_hrdata", hrdata, 64'd0);
    chk("t5_rst_cs", 64'(sramcs0), 64'd0);
    chk("t5_rst_wen", 64'(sramwen), 64'd0);
    chk("t5_rst_hreadyout", 64'(hreadyout), 64'd1);
    tick();
    hreset = 1'b0;
    @(negedge hclk); chk("t5_no_drain", 64'(sramcs0), 64'd0); tick();
    ap(1'b1, NSEQ, 1'b0, 3'd3, 32'h18); tick();
    ap(1'b0, IDLE, 1'b0, 3'd0, 32'h0);
    @(negedge hclk); chk("t5_old_data", hrdata, 64'h0123456789ABCDEF); tick();

    // Address wrap, HSEL=0 and BUSY are not transfers
    ap(1'b1, NSEQ, 1'b0, 3'd3, 32'h00002008);
    @(negedge hclk); chk("t6_wrap_addr", 64'(sramaddr), 64'd1); tick();
    ap(1'b0, NSEQ, 1'b0, 3'd3, 32'h08);
    @(negedge hclk);
    chk("t6_wrap_data", hrdata, 64'h1122AB4455667788);
    chk("t6_nosel_cs", 64'(sramcs0), 64'd0);
    tick();
    ap(1'b1, BUSY, 1'b0, 3'd3, 32'h08);
    @(negedge hclk);
    chk("t6_nosel_hrdata", hrdata, 64'd0);
    chk("t6_busy_cs", 64'(sramcs0), 64'd0);
    tick();

`ifdef AHB_SRAM_ERR_EN
    // Misaligned word read @0x0A: two-cycle ERROR, no SRAM access
    ap(1'b1, NSEQ, 1'b0, 3'd2, 32'h0A);
    @(negedge hclk);
    chk("e_ap_cs", 64'(sramcs0), 64'd0);
    chk("e_ap_hresp", 64'(hresp), 64'd0);
    tick();
    ap(1'b0, IDLE, 1'b0, 3'd0, 32'h0);
    @(negedge hclk);
    chk("e1_hreadyout", 64'(hreadyout), 64'd0);
    chk("e1_hresp", 64'(hresp), 64'd1);
    chk("e1_cs", 64'(sramcs0), 64'd0);
    tick();
    @(negedge hclk);
    chk("e2_hreadyout", 64'(hreadyout), 64'd1);
    chk("e2_hresp", 64'(hresp), 64'd1);
    chk("e2_cs", 64'(sramcs0), 64'd0);
    tick();
    ap(1'b1, NSEQ, 1'b0, 3'd3, 32'h08);
    @(negedge hclk);
    chk("e_next_hresp", 64'(hresp), 64'd0);
    chk("e_next_cs", 64'(sramcs0), 64'd1);
    tick();
    ap(1'b0, IDLE, 1'b0, 3'd0, 32'h0);
    @(negedge hclk);
    chk("e_next_data", hrdata, 64'h1122AB4455667788);
    chk("e_next_ok", 64'(hresp), 64'd0);
    tick();
`else
    // Misaligned halfword @0x0B aligns down to lanes 2-3; HSIZE=5 acts as DW
    ap(1'b1, NSEQ, 1'b1, 3'd1, 32'h0B); tick();
    ap(1'b0, IDLE, 1'b0, 3'd0, 32'h0); hwdata = 64'h0000000099990000;
    @(negedge hclk); chk("a_h_wen", 64'(sramwen), 64'h0C); tick();
    ap(1'b1, NSEQ, 1'b1, 3'd5, 32'h08); tick();
    ap(1'b0, IDLE, 1'b0, 3'd0, 32'h0); hwdata = 64'h0F0E0D0C0B0A0908;
    @(negedge hclk);
    chk("a_sz5_wen", 64'(sramwen), 64'hFF);
    chk("a_hresp", 64'(hresp), 64'd0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
